// File: rtl/spi_regfile_pkg.sv
// Frame layout helpers and opcodes shared by the SPI register-file target.
// Field positions are bit indices into the fully shifted frame (LSB = last bit received).
package spi_regfile_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DATA_LSB = 0;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rw_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// STAGES-flop synchroniser with one extra delay flop for rise/fall detection.
// Latency STAGES clk cycles to sync, edges flagged for one cycle; no backpressure.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            dly   <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            dly   <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target onto a NUM_REGS x DATA_W register bank with readback, write strobe and frame errors.
// Writes land SYNC_STAGES+2 clk after nCS rises; the SPI controller cannot be stalled.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W  = frame_width(ADDR_W, DATA_W);
    localparam int RW_BIT   = rw_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int CNT_W    = $clog2(FRAME_W + 2);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]    CNT_OVER    = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0]    CNT_PRE_HDR = CNT_W'(ADDR_W);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s;
    logic [1:0] unused_copi_edges;
    logic unused_sclk_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(nCS), .sync(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(COPI), .sync(copi_s),
        .rise(unused_copi_edges[1]), .fall(unused_copi_edges[0])
    );
    assign unused_sclk_s = sclk_s;

    logic [SETTLE_W-1:0]        settle_cnt;
    logic                       in_frame;
    logic [CNT_W-1:0]           bit_cnt;
    logic [FRAME_W-1:0]         in_sr;
    logic [DATA_W-1:0]          out_sr;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    logic               settled, frame_start, frame_end, sample, shift;
    logic [FRAME_W-1:0] in_sr_next;
    logic               hdr_rw, load_rd, commit, f_rw;
    logic [ADDR_W-1:0]  hdr_addr, f_addr;
    logic [DATA_W-1:0]  f_data, rd_word;

    // Synchroniser reset values mimic an idle bus, so edges are ignored until the chains have flushed
    assign settled     = (settle_cnt == SETTLE_DONE);
    assign frame_start = ncs_fall && settled;
    assign frame_end   = ncs_rise && in_frame;
    assign sample      = sclk_rise && !ncs_s && in_frame;
    assign shift       = sclk_fall && !ncs_s && in_frame;

    assign in_sr_next = {in_sr[FRAME_W-2:0], copi_s};
    assign hdr_rw     = in_sr_next[ADDR_W];
    assign hdr_addr   = in_sr_next[ADDR_W-1:0];
    assign load_rd    = sample && (bit_cnt == CNT_PRE_HDR) && (hdr_rw == OP_READ);

    assign f_rw   = in_sr[RW_BIT];
    assign f_addr = in_sr[ADDR_LSB +: ADDR_W];
    assign f_data = in_sr[DATA_LSB +: DATA_W];
    assign commit = frame_end && (bit_cnt == CNT_FULL) && (f_rw == OP_WRITE)
                    && ({1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            in_frame   <= 1'b0;
            bit_cnt    <= '0;
            in_sr      <= '0;
            out_sr     <= '0;
            CIPO       <= 1'b0;
            cipo_oe    <= 1'b0;
        end else begin
            if (!settled) settle_cnt <= settle_cnt + 1'b1;
            cipo_oe <= !ncs_s;
            if (frame_start) begin
                in_frame <= 1'b1;
                bit_cnt  <= '0;
                in_sr    <= '0;
                out_sr   <= '0;
                CIPO     <= 1'b0;
            end else if (frame_end) begin
                in_frame <= 1'b0;
                out_sr   <= '0;
                CIPO     <= 1'b0;
            end else begin
                if (sample) begin
                    in_sr <= in_sr_next;
                    if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + 1'b1;
                end
                // Snapshot at address completion; later writes cannot disturb bits in flight
                if (load_rd) begin
                    out_sr <= rd_word;
                end else if (shift) begin
                    CIPO   <= out_sr[DATA_W-1];
                    out_sr <= out_sr << 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= commit;
            frame_err <= frame_end && (bit_cnt != CNT_FULL);
            if (commit) begin
                wr_addr <= f_addr;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (f_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= f_data;
                end
            end
        end
    end

    assign regs_out = regs_q;

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- Parametrised SPI mode-0 target (CPOL=0, CPHA=0) exposing a bank of NUM_REGS × DATA_W control registers to an external controller.
- Successor to the fixed 5×8-bit write-only SPI register block. Adds:
  - generic register count and width,
  - readback on CIPO,
  - frame-error reporting,
  - per-write strobe.
- Sits between the chip pins (nCS/SCLK/COPI/CIPO) and the output/PWM enable logic, which consumes the flat regs_out bus.

Parameters:
- NUM_REGS, 8: number of registers; 1..2^ADDR_W.
- DATA_W, 8: register width in bits.
- ADDR_W, 7: address field width.
- SYNC_STAGES, 2: synchroniser flops per SPI input; minimum 2.
- FRAME_W, 1+ADDR_W+DATA_W: derived localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- nCS  in  1  SPI chip select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock, asynchronous to clk.
- COPI  in  1  controller-out data.
- CIPO  out  1  controller-in data.
- cipo_oe  out  1  pad output enable, high while selected.
- regs_out  out  NUM_REGS*DATA_W  register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  ADDR_W  address of the last committed write.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset: rst_n is asynchronous and active-low. All of the following reset to 0:
  - regs_out, CIPO, cipo_oe, wr_strobe, wr_addr, frame_err, bit counter, shift registers.
  - Synchroniser chains: nCS chain resets to all-1; SCLK and COPI chains reset to all-0.
- Input sync: each input passes through SYNC_STAGES flops, giving ncs_s, sclk_s, copi_s. One further flop per signal (ncs_d, sclk_d) provides edge detection.
- Edge definitions:
  - frame start: ncs_s=0 and ncs_d=1.
  - frame end: ncs_s=1 and ncs_d=0.
  - sample edge: sclk_s=1, sclk_d=0, ncs_s=0.
  - shift edge: sclk_s=0, sclk_d=1, ncs_s=0.
- Frame format, MSB first: bit0 is R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. Default frame is 16 bits.
- Frame start clears the input shift register and the bit counter.
- On each sample edge:
  - shift copi_s into the input shift register.
  - the counter increments, saturating at FRAME_W+1 (this value means overlength).
- Write commit: on frame end with count==FRAME_W and R/W=1:
  - If addr<NUM_REGS: the register updates on the next clk edge, and wr_strobe=1 with wr_addr=addr in that same cycle.
  - If addr>=NUM_REGS: the write is ignored, with no strobe and no error.
- Frame error: frame end with count!=FRAME_W (short or overlength) pulses frame_err for one cycle. No register changes. This applies to both reads and writes.
- Read:
  - When count reaches 1+ADDR_W with R/W=0, load the output shift register with reg[addr], or 0 if addr>=NUM_REGS.
  - On each subsequent shift edge, CIPO <= output-shift MSB and the register shifts left, filling with 0.
  - CIPO holds 0 at all other times.
  - Read data is a snapshot taken at address completion. A write committed later does not alter bits already in flight.
- cipo_oe = registered copy of !ncs_s.
- Simultaneous events: frame end and a sample edge in the same cycle → the frame end wins and the sample is dropped. Frame start clears any residual state.
- Reset mid-frame: state is discarded and registers return to 0. The next frame is only recognised after nCS is seen high then low.
- Timing constraint: SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk cycles. nCS must stay high ≥ SYNC_STAGES+2 cycles between frames.
- Latency: a write is visible on regs_out SYNC_STAGES+2 clk cycles after the raw nCS rise.

Decomposition:
- Package spi_regfile_pkg:
  - frame field offsets (RW_BIT, ADDR_LSB, DATA_LSB),
  - FRAME_W computation function,
  - READ/WRITE opcode constants.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall detect, instantiated three times.

Test Plan:
- Write frame R/W=1, addr 0x02, data 0xA5 → regs_out[23:16]=0xA5; wr_strobe pulses once with wr_addr=2; all other registers stay 0.
- Read frame addr 0x02 after the write above → CIPO shifts 1,0,1,0,0,1,0,1 across the 8 data clocks; cipo_oe is high only while nCS is low.
- Write addr 0x09 with NUM_REGS=8 → no register changes, no wr_strobe, no frame_err. A read of 0x09 returns 0x00.
- 15-bit frame and 17-bit write frame to addr 0 → frame_err pulses once for each; reg0 is unchanged.
- Assert rst_n low after 10 bits of a write, then run a full write of 0x3C to addr 1 → reg1=0x3C and all other registers are 0.
- Two back-to-back writes at minimum nCS gap, addr 4=0xFF then addr 4=0x00 → wr_strobe pulses twice and the final reg4=0x00.
